alu_seq: RTL and testbench

- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds an internal carry flag register consumed by ADC/SBB, a zero flag, and multi-bit shifts/rotates (including through carry) executed one bit per cycle.
- Uses a start/busy/done handshake.
- Sits between the accumulator/operand path and the control FSM; the control FSM stalls on busy.

---
 rtl/alu_seq.sv | 152 +++++++++++++++
 tb/tb_alu_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a carry flag and one-bit-per-cycle shifts/rotates.
// ALU ops finish on the sampling edge. Shift ops run for shamt cycles in SHIFT
// with busy high. done pulses for one cycle when a result is ready.
module alu_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               shift_en,
  input  logic [2:0]         alu_op,
  input  logic [2:0]         shift_op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [WIDTH-1:0]   a_out,
  output logic               carry_out,
  output logic               zero,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_ADC = 3'b010,
                         OP_SBB = 3'b011, OP_AND = 3'b100, OP_OR  = 3'b101,
                         OP_XOR = 3'b110, OP_LD  = 3'b111;

  localparam logic [2:0] SH_SLL = 3'b000, SH_SRL = 3'b001, SH_SRA = 3'b010,
                         SH_ROL = 3'b011, SH_ROR = 3'b100, SH_RLC = 3'b101,
                         SH_RRC = 3'b110, SH_RSV = 3'b111;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic                 carry_q, carry_d;
  logic                 done_q, done_d;
  logic [SHAMT_W-1:0]   count_q, count_d;
  logic [2:0]           op_q, op_d;

  // Returns {carry, result}. Subtraction carry is "no borrow", so the borrow
  // bit of the WIDTH+1 difference is inverted. Logic ops pass carry through.
  function automatic logic [WIDTH:0] alu_calc(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic cin);
    logic [WIDTH:0] s;
    s = {cin, a};
    case (op)
      OP_ADD: s = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        s[WIDTH] = ~s[WIDTH];
      end
      OP_ADC: s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      OP_SBB: begin
        s = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, ~cin};
        s[WIDTH] = ~s[WIDTH];
      end
      OP_AND: s = {cin, a & b};
      OP_OR:  s = {cin, a | b};
      OP_XOR: s = {cin, a ^ b};
      OP_LD:  s = {cin, b};
      default: s = {cin, a};
    endcase
    return s;
  endfunction

  // One-bit shift/rotate step, returns {carry, result}.
  function automatic logic [WIDTH:0] shift_step(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic cin);
    logic signed [WIDTH-1:0] sa;
    logic [WIDTH:0]          s;
    sa = $signed(a);
    s  = {cin, a};
    case (op)
      SH_SLL: s = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      SH_SRL: s = {a[0], 1'b0, a[WIDTH-1:1]};
      SH_SRA: s = {a[0], $unsigned(sa >>> 1)};
      SH_ROL: s = {a[WIDTH-1], a[WIDTH-2:0], a[WIDTH-1]};
      SH_ROR: s = {a[0], a[0], a[WIDTH-1:1]};
      SH_RLC: s = {a[WIDTH-1], a[WIDTH-2:0], cin};
      SH_RRC: s = {a[0], cin, a[WIDTH-1:1]};
      default: s = {cin, a};
    endcase
    return s;
  endfunction

  // State and datapath registers; reset clears everything, including mid-shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

  // Next-state and datapath logic; everything holds unless an op is running.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    count_d = count_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!shift_en) begin
            {carry_d, a_d} = alu_calc(alu_op, a_in, operand, carry_q);
            done_d = 1'b1;
          end else begin
            a_d = a_in;
            if (shamt == '0 || shift_op == SH_RSV) begin
              done_d = 1'b1;
            end else begin
              count_d = shamt;
              op_d    = shift_op;
              state_d = SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        {carry_d, a_d} = shift_step(op_q, a_q, carry_q);
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  assign a_out     = a_q;
  assign carry_out = carry_q;
  assign zero      = (a_q == '0);
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=8) with hand-computed expectations.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset, start, shift_en;
  logic [2:0] alu_op, shift_op, shamt;
  logic [7:0] a_in, operand;
  logic [7:0] a_out;
  logic       carry_out, zero, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .shift_en(shift_en),
    .alu_op(alu_op), .shift_op(shift_op), .shamt(shamt),
    .a_in(a_in), .operand(operand),
    .a_out(a_out), .carry_out(carry_out), .zero(zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    shift_en = 1'b0; alu_op = op; a_in = a; operand = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_shf(input logic [2:0] op, input logic [2:0] sh, input logic [7:0] a);
    shift_en = 1'b1; shift_op = op; shamt = sh; a_in = a; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; shift_en = 1'b0; alu_op = 3'd0; shift_op = 3'd0;
    shamt = 3'd0; a_in = 8'h00; operand = 8'h00;
    tick(); tick();
    check("rst_a", 32'(a_out), 32'h00);
    check("rst_c", 32'(carry_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    reset = 1'b0;

    // ADD with carry out
    do_alu(3'b000, 8'hF0, 8'h20);
    check("add_a", 32'(a_out), 32'h10);
    check("add_c", 32'(carry_out), 32'd1);
    check("add_zero", 32'(zero), 32'd0);
    check("add_done", 32'(done), 32'd1);
    tick();
    check("add_done_pulse", 32'(done), 32'd0);
    check("idle_hold_a", 32'(a_out), 32'h10);
    check("idle_hold_c", 32'(carry_out), 32'd1);

    // SUB with borrow, then back-to-back SBB
    do_alu(3'b001, 8'h03, 8'h05);
    check("sub_a", 32'(a_out), 32'hFE);
    check("sub_c", 32'(carry_out), 32'd0);
    do_alu(3'b011, 8'h10, 8'h01);
    check("sbb1_a", 32'(a_out), 32'h0E);
    check("sbb1_c", 32'(carry_out), 32'd1);
    check("sbb1_done", 32'(done), 32'd1);
    do_alu(3'b011, 8'h10, 8'h01);
    check("sbb2_a", 32'(a_out), 32'h0F);
    check("sbb2_c", 32'(carry_out), 32'd1);

    // ADC: 0x7F + 0x00 + carry(1)
    do_alu(3'b010, 8'h7F, 8'h00);
    check("adc_a", 32'(a_out), 32'h80);
    check("adc_c", 32'(carry_out), 32'd0);

    // SRA 0x80 by 3, cycle by cycle
    do_shf(3'b010, 3'd3, 8'h80);
    check("sra_load_a", 32'(a_out), 32'h80);
    check("sra_busy0", 32'(busy), 32'd1);
    check("sra_done0", 32'(done), 32'd0);
    tick();
    check("sra_s1", 32'(a_out), 32'hC0);
    check("sra_busy1", 32'(busy), 32'd1);
    tick();
    check("sra_s2", 32'(a_out), 32'hE0);
    check("sra_busy2", 32'(busy), 32'd1);
    tick();
    check("sra_s3", 32'(a_out), 32'hF0);
    check("sra_done", 32'(done), 32'd1);
    check("sra_busy3", 32'(busy), 32'd0);
    check("sra_c", 32'(carry_out), 32'd0);

    // Preload carry, then RLC / RRC
    do_alu(3'b000, 8'hFF, 8'h01);
    check("pre_a", 32'(a_out), 32'h00);
    check("pre_c", 32'(carry_out), 32'd1);
    do_shf(3'b101, 3'd2, 8'h80);
    wait_done("rlc_lat", 2);
    check("rlc_a", 32'(a_out), 32'h03);
    check("rlc_c", 32'(carry_out), 32'd0);
    do_shf(3'b110, 3'd1, 8'h01);
    wait_done("rrc_lat", 1);
    check("rrc_a", 32'(a_out), 32'h00);
    check("rrc_c", 32'(carry_out), 32'd1);
    check("rrc_zero", 32'(zero), 32'd1);

    // Logic op keeps carry; zero-count shift is a plain load
    do_alu(3'b100, 8'hF0, 8'h0F);
    check("and_a", 32'(a_out), 32'h00);
    check("and_zero", 32'(zero), 32'd1);
    check("and_c", 32'(carry_out), 32'd1);
    do_shf(3'b000, 3'd0, 8'h5A);
    check("sll0_a", 32'(a_out), 32'h5A);
    check("sll0_done", 32'(done), 32'd1);
    check("sll0_busy", 32'(busy), 32'd0);
    check("sll0_c", 32'(carry_out), 32'd1);

    // ROL by 7 with a spurious start mid-shift
    do_shf(3'b011, 3'd7, 8'h5A);
    tick();
    shift_en = 1'b0; alu_op = 3'b111; a_in = 8'hFF; operand = 8'h00;
    shamt = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("rol_busy_mid", 32'(busy), 32'd1);
    wait_done("rol_lat", 5);
    check("rol_a", 32'(a_out), 32'h2D);
    check("rol_c", 32'(carry_out), 32'd1);
    check("rol_busy_end", 32'(busy), 32'd0);

    // Reset in the middle of a shift
    do_shf(3'b011, 3'd7, 8'h5A);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mrst_a", 32'(a_out), 32'h00);
    check("mrst_c", 32'(carry_out), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_zero", 32'(zero), 32'd1);
    reset = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_a", 32'(a_out), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
